// File: rtl/mb_config_loader.sv
// Memory-bank configuration writer.
// Bitstream words arrive on a valid/ready stream and are assembled into a row
// image (the shadow register). Each finished row is presented on the bit-line
// bus and then committed with a one-hot word-line pulse. Rows go out in order
// from row 0 to row WL_WIDTH-1.
//
// Stream handshake: a word moves when s_valid && s_ready are both high at a
// rising edge of clk. s_ready is high only in LOAD. s_data is ignored
// whenever s_ready is low, so a row never takes more than WORDS words.
module mb_config_loader #(
  parameter int BL_WIDTH   = 514,
  parameter int WL_WIDTH   = 407,
  parameter int DATA_WIDTH = 32,
  parameter int WL_PULSE   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [BL_WIDTH-1:0]   bl_config_region_0,
  output logic [WL_WIDTH-1:0]   wl_config_region_0,
  output logic                  busy,
  output logic                  done
);

  localparam int WORDS  = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PCNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  localparam logic [ROW_W-1:0]    LAST_ROW  = ROW_W'(WL_WIDTH - 1);
  localparam logic [WORD_W-1:0]   LAST_WORD = WORD_W'(WORDS - 1);
  localparam logic [PCNT_W-1:0]   LAST_PCNT = PCNT_W'(WL_PULSE - 1);
  localparam logic [WL_WIDTH-1:0] WL_ONE    = WL_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [ROW_W-1:0]    row;
  logic [WORD_W-1:0]   word;
  logic [PCNT_W-1:0]   pcnt;
  logic [BL_WIDTH-1:0] shadow;
  logic [BL_WIDTH-1:0] shadow_wr;
  logic                xfer;

  assign xfer = s_valid && s_ready;

  // Shadow image with the incoming word merged into slot `word`; bits of the
  // last word that fall beyond BL_WIDTH have no home and are dropped.
  always_comb begin
    shadow_wr = shadow;
    for (int b = 0; b < BL_WIDTH; b++) begin
      if ((b / DATA_WIDTH) == int'(word)) begin
        shadow_wr[b] = s_data[b % DATA_WIDTH];
      end
    end
  end

  // Sequencer: every output is a register updated together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      row                <= '0;
      word               <= '0;
      pcnt               <= '0;
      shadow             <= '0;
      s_ready            <= 1'b0;
      bl_config_region_0 <= '0;
      wl_config_region_0 <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else if (abort) begin
      state              <= IDLE;
      row                <= '0;
      word               <= '0;
      pcnt               <= '0;
      shadow             <= '0;
      s_ready            <= 1'b0;
      bl_config_region_0 <= '0;
      wl_config_region_0 <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= LOAD;
            row     <= '0;
            word    <= '0;
            shadow  <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            shadow <= shadow_wr;
            if (word == LAST_WORD) begin
              state              <= SETUP;
              s_ready            <= 1'b0;
              bl_config_region_0 <= shadow_wr;
            end else begin
              word <= word + WORD_W'(1);
            end
          end
        end
        SETUP: begin
          state              <= PULSE;
          pcnt               <= '0;
          wl_config_region_0 <= WL_ONE << row;
        end
        PULSE: begin
          if (pcnt == LAST_PCNT) begin
            state              <= HOLD;
            wl_config_region_0 <= '0;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        HOLD: begin
          bl_config_region_0 <= '0;
          if (row == LAST_ROW) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= LOAD;
            row     <= row + ROW_W'(1);
            word    <= '0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_config_loader.sv
// Bench for mb_config_loader: a small 8x3 array, a partial-last-word 10x1
// array, and the default 514x407 array. Inputs change 1 time unit after the
// falling clock edge. Outputs are sampled on the falling edge.
module tb_mb_config_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1023:0] ONE = 1024'd1;

  function automatic void chk(string name, logic [1023:0] act, logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // ---------------- small instance: BL=8, WL=3, DW=4, pulse=2 ----------------
  logic       s_start, s_abort, s_valid, s_ready, s_busy, s_done;
  logic [3:0] s_data;
  logic [7:0] s_bl;
  logic [2:0] s_wl;

  mb_config_loader #(.BL_WIDTH(8), .WL_WIDTH(3), .DATA_WIDTH(4), .WL_PULSE(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bl_config_region_0(s_bl), .wl_config_region_0(s_wl),
    .busy(s_busy), .done(s_done)
  );

  // ---------------- partial instance: BL=10, WL=1, DW=4, pulse=1 ----------------
  logic       p_start, p_abort, p_valid, p_ready, p_busy, p_done;
  logic [3:0] p_data;
  logic [9:0] p_bl;
  logic [0:0] p_wl;

  mb_config_loader #(.BL_WIDTH(10), .WL_WIDTH(1), .DATA_WIDTH(4), .WL_PULSE(1)) u_part (
    .clk(clk), .reset(reset), .start(p_start), .abort(p_abort),
    .s_data(p_data), .s_valid(p_valid), .s_ready(p_ready),
    .bl_config_region_0(p_bl), .wl_config_region_0(p_wl),
    .busy(p_busy), .done(p_done)
  );

  // ---------------- default instance ----------------
  logic         d_start, d_abort, d_valid, d_ready, d_busy, d_done;
  logic [31:0]  d_data;
  logic [513:0] d_bl;
  logic [406:0] d_wl;

  mb_config_loader u_def (
    .clk(clk), .reset(reset), .start(d_start), .abort(d_abort),
    .s_data(d_data), .s_valid(d_valid), .s_ready(d_ready),
    .bl_config_region_0(d_bl), .wl_config_region_0(d_wl),
    .busy(d_busy), .done(d_done)
  );

  // ---------------- stream drivers: present queue head, pop on accept ----------------
  logic [3:0]  s_word_q[$];
  logic [3:0]  p_word_q[$];
  logic [31:0] d_word_q[$];
  bit          s_stall = 1'b0;
  bit          s_phase = 1'b0;
  int          s_pops  = 0;

  always begin
    cyc();
    s_phase = ~s_phase;
    if (s_word_q.size() != 0 && !(s_stall && s_phase)) begin
      s_valid = 1'b1;
      s_data  = s_word_q[0];
      if (s_ready) begin
        void'(s_word_q.pop_front());
        s_pops++;
      end
    end else begin
      s_valid = 1'b0;
      s_data  = 4'($urandom);
    end
  end

  always begin
    cyc();
    if (p_word_q.size() != 0) begin
      p_valid = 1'b1;
      p_data  = p_word_q[0];
      if (p_ready) void'(p_word_q.pop_front());
    end else begin
      p_valid = 1'b0;
      p_data  = 4'($urandom);
    end
  end

  always begin
    cyc();
    if (d_word_q.size() != 0) begin
      d_valid = 1'b1;
      d_data  = d_word_q[0];
      if (d_ready) void'(d_word_q.pop_front());
    end else begin
      d_valid = 1'b0;
      d_data  = $urandom;
    end
  end

  // ---------------- scoreboards / monitors ----------------
  logic [10:0]  s_exp_q[$];   // {wl, bl} expected per committed row
  logic [9:0]   p_exp_q[$];
  logic [513:0] d_exp_q[$];

  logic [10:0]  s_cur;
  logic [7:0]   s_bl_prev;
  logic [2:0]   s_wl_prev;
  int           s_plen, s_rows = 0, s_rows_base = 0, s_pops_base = 0;

  always @(negedge clk) begin
    if (reset) begin
      s_wl_prev = '0;
      s_bl_prev = '0;
    end else begin
      chk("s_wl_onehot", $onehot0(s_wl), 1'b1);
      if (s_wl != 0 && s_wl_prev == 0) begin
        if (s_exp_q.size() == 0) begin
          chk("s_unexpected_row", s_wl, 0);
          s_cur = '0;
        end else begin
          s_cur = s_exp_q.pop_front();
        end
        chk("s_wl_row", s_wl, s_cur[10:8]);
        chk("s_bl_pulse", s_bl, s_cur[7:0]);
        chk("s_bl_setup", s_bl_prev, s_cur[7:0]);
        chk("s_words_before_wl", s_pops - s_pops_base, 2 * (s_rows - s_rows_base + 1));
        s_plen = 1;
        s_rows++;
      end else if (s_wl != 0) begin
        s_plen++;
        chk("s_wl_stable", s_wl, s_wl_prev);
        chk("s_bl_pulse_stable", s_bl, s_cur[7:0]);
      end else if (s_wl_prev != 0 && !s_abort) begin
        chk("s_pulse_len", s_plen, 2);
        chk("s_bl_hold", s_bl, s_cur[7:0]);
      end
      s_wl_prev = s_wl;
      s_bl_prev = s_bl;
    end
  end

  logic [9:0] p_cur;
  logic [0:0] p_wl_prev;
  int         p_plen, p_rows = 0;

  always @(negedge clk) begin
    if (reset) begin
      p_wl_prev = '0;
    end else begin
      if (p_wl != 0 && p_wl_prev == 0) begin
        p_cur = (p_exp_q.size() != 0) ? p_exp_q.pop_front() : 10'h000;
        chk("p_bl_pulse", p_bl, p_cur);
        p_plen = 1;
        p_rows++;
      end else if (p_wl != 0) begin
        p_plen++;
      end else if (p_wl_prev != 0) begin
        chk("p_pulse_len", p_plen, 1);
        chk("p_bl_hold", p_bl, p_cur);
      end
      p_wl_prev = p_wl;
    end
  end

  logic [513:0] d_cur;
  logic [406:0] d_wl_prev;
  int           d_plen, d_rows = 0, d_busy_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      d_wl_prev = '0;
    end else begin
      if (d_busy) d_busy_cnt++;
      chk("d_wl_onehot", $onehot0(d_wl), 1'b1);
      if (d_wl != 0 && d_wl_prev == 0) begin
        d_cur = (d_exp_q.size() != 0) ? d_exp_q.pop_front() : '0;
        chk("d_wl_row", d_wl, ONE << d_rows);
        chk("d_bl_row", d_bl, d_cur);
        d_plen = 1;
        d_rows++;
      end else if (d_wl != 0) begin
        d_plen++;
      end else if (d_wl_prev != 0) begin
        chk("d_pulse_len", d_plen, 2);
      end
      d_wl_prev = d_wl;
    end
  end

  // ---------------- directed table for the small array ----------------
  typedef struct packed {
    logic [3:0] w0;
    logic [3:0] w1;
    logic [2:0] wl;
    logic [7:0] bl;
  } vec_t;

  vec_t tbl[3];

  task automatic load_small();
    for (int i = 0; i < 3; i++) begin
      s_word_q.push_back(tbl[i].w0);
      s_word_q.push_back(tbl[i].w1);
      s_exp_q.push_back({tbl[i].wl, tbl[i].bl});
    end
  endtask

  task automatic start_small();
    s_pops_base = s_pops;
    s_rows_base = s_rows;
    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
  endtask

  // Counts edges from the start edge until done is seen.
  task automatic wait_small_done(input int limit, output int n);
    n = 1;
    while (!s_done && n < limit) begin
      cyc();
      n++;
    end
  endtask

  int n;

  initial begin
    reset   = 1'b1;
    s_start = 1'b0; s_abort = 1'b0;
    p_start = 1'b0; p_abort = 1'b0;
    d_start = 1'b0; d_abort = 1'b0;
    tbl[0] = '{w0: 4'h5, w1: 4'hA, wl: 3'b001, bl: 8'hA5};
    tbl[1] = '{w0: 4'hF, w1: 4'h0, wl: 3'b010, bl: 8'h0F};
    tbl[2] = '{w0: 4'h3, w1: 4'hC, wl: 3'b100, bl: 8'hC3};

    // Reset state
    repeat (3) cyc();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s_bl", s_bl, 0);
    chk("rst_s_wl", s_wl, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_s_done", s_done, 0);
    chk("rst_d_wl", d_wl, 0);
    reset = 1'b0;
    cyc();

    // Pass 1: continuous stream
    load_small();
    start_small();
    chk("p1_ready_after_start", s_ready, 1);
    chk("p1_busy_after_start", s_busy, 1);
    chk("p1_bl_in_load", s_bl, 0);
    wait_small_done(200, n);
    chk("p1_done", s_done, 1);
    chk("p1_cycles", n, 19);
    chk("p1_rows", s_rows - s_rows_base, 3);
    chk("p1_exp_left", s_exp_q.size(), 0);
    repeat (2) cyc();
    chk("p1_done_sticky", s_done, 1);
    chk("p1_done_bl", s_bl, 0);
    chk("p1_done_wl", s_wl, 0);
    chk("p1_done_ready", s_ready, 0);
    chk("p1_done_busy", s_busy, 0);

    // Pass 2: s_valid toggling, restarted from DONE
    s_stall = 1'b1;
    load_small();
    start_small();
    chk("p2_done_cleared", s_done, 0);
    wait_small_done(400, n);
    s_stall = 1'b0;
    chk("p2_done", s_done, 1);
    chk("p2_rows", s_rows - s_rows_base, 3);
    chk("p2_slower", n > 19, 1);
    chk("p2_exp_left", s_exp_q.size(), 0);

    // Abort during row 1 pulse
    load_small();
    start_small();
    n = 0;
    while (s_wl != 3'b010 && n < 60) begin
      cyc();
      n++;
    end
    chk("ab_reach_row1", s_wl, 3'b010);
    s_abort = 1'b1;
    cyc();
    chk("ab_wl", s_wl, 0);
    chk("ab_bl", s_bl, 0);
    chk("ab_busy", s_busy, 0);
    chk("ab_done", s_done, 0);
    chk("ab_ready", s_ready, 0);
    s_abort = 1'b0;
    s_word_q.delete();
    s_exp_q.delete();
    cyc();
    chk("ab_idle_ready", s_ready, 0);

    // Restart after abort, with a start pulse while busy that must be ignored
    load_small();
    start_small();
    repeat (3) cyc();
    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
    wait_small_done(200, n);
    chk("rs_done", s_done, 1);
    chk("rs_rows", s_rows - s_rows_base, 3);
    chk("rs_exp_left", s_exp_q.size(), 0);

    // Asynchronous reset while a word line is high
    load_small();
    start_small();
    n = 0;
    while (s_wl == 3'b000 && n < 60) begin
      cyc();
      n++;
    end
    chk("ar_reach_pulse", s_wl, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("ar_wl_async", s_wl, 0);
    chk("ar_bl_async", s_bl, 0);
    chk("ar_busy_async", s_busy, 0);
    chk("ar_ready_async", s_ready, 0);
    s_word_q.delete();
    s_exp_q.delete();
    cyc();
    reset = 1'b0;
    repeat (2) cyc();
    chk("ar_idle_ready", s_ready, 0);
    chk("ar_idle_busy", s_busy, 0);
    chk("ar_idle_done", s_done, 0);

    // Partial last word plus one surplus word that must stay unconsumed
    p_word_q.push_back(4'hF);
    p_word_q.push_back(4'hF);
    p_word_q.push_back(4'hF);
    p_word_q.push_back(4'h7);
    p_exp_q.push_back(10'h3FF);
    p_start = 1'b1;
    cyc();
    p_start = 1'b0;
    n = 1;
    while (!p_done && n < 50) begin
      cyc();
      n++;
    end
    chk("pt_done", p_done, 1);
    chk("pt_cycles", n, 7);
    chk("pt_rows", p_rows, 1);
    chk("pt_extra_left", p_word_q.size(), 1);
    chk("pt_bl_after", p_bl, 0);

    // Default geometry with pseudo-random data
    for (int r = 0; r < 407; r++) begin
      logic [543:0] acc;
      logic [31:0]  w;
      acc = '0;
      for (int k = 0; k < 17; k++) begin
        w = $urandom;
        d_word_q.push_back(w);
        acc[k*32 +: 32] = w;
      end
      d_exp_q.push_back(acc[513:0]);
    end
    d_start = 1'b1;
    cyc();
    d_start = 1'b0;
    n = 1;
    while (!d_done && n < 9000) begin
      cyc();
      n++;
    end
    chk("df_done", d_done, 1);
    chk("df_busy_cycles", d_busy_cnt, 8547);
    chk("df_edges", n, 8548);
    chk("df_rows", d_rows, 407);
    chk("df_exp_left", d_exp_q.size(), 0);
    chk("df_words_left", d_word_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
